// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the byte-addressed, big-endian instruction memory.
// Accepts 32-bit program words on a valid/ready stream and splits each word
// into four byte writes, MSB first, at consecutive byte addresses starting at
// BASE_ADDR. The CPU pipeline is stalled for the whole load. A load ends when
// a word flagged last has been written, or when the source offers a word that
// no longer fits (overflow).
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   start       one-cycle load request, honoured only when idle
//   word_valid  source presents word_data / word_last
//   word_data   program word, [31:24] lands at the lowest address
//   word_last   marks the final word of the program
//   word_ready  loader accepts a word this cycle (function of state only)
//   mem_we      byte write strobe to the instruction memory
//   mem_addr    byte address of the write
//   mem_wdata   byte to write
//   cpu_stall   pipeline stall, high for the whole load
//   busy        high in every state except idle
//   done        one-cycle pulse when a load terminates
//   overflow    sticky error flag, cleared by start or reset
//   word_count  words fully written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [31:0]           word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-2:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_FIN
  } state_e;

  // The word pointer carries one extra bit so that stepping past the last
  // word of a full memory cannot wrap back to address 0.
  localparam int unsigned          PTR_W          = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]  LAST_WORD_ADDR = PTR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_WIDTH:0]  BASE_PTR       = PTR_W'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  last_q, last_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH-2:0] count_q, count_d;
  logic                  room;

  // A whole word still fits at the current pointer.
  assign room = (addr_q <= LAST_WORD_ADDR);

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    overflow_d  = overflow_q;
    count_d     = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          addr_d     = BASE_PTR;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          if (room) begin
            // Byte strobes are registered, so the first byte is staged here
            // and appears during WR0.
            state_d     = S_WR0;
            data_d      = word_data;
            last_d      = word_last;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[ADDR_WIDTH-1:0];
            mem_wdata_d = word_data[31:24];
          end else begin
            state_d    = S_FIN;
            overflow_d = 1'b1;
          end
        end
      end
      S_WR0: begin
        state_d     = S_WR1;
        mem_we_d    = 1'b1;
        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
        mem_wdata_d = data_q[23:16];
      end
      S_WR1: begin
        state_d     = S_WR2;
        mem_we_d    = 1'b1;
        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
        mem_wdata_d = data_q[15:8];
      end
      S_WR2: begin
        state_d     = S_WR3;
        mem_we_d    = 1'b1;
        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
        mem_wdata_d = data_q[7:0];
      end
      S_WR3: begin
        addr_d  = addr_q + PTR_W'(4);
        count_d = count_q + (ADDR_WIDTH-1)'(1);
        state_d = last_q ? S_FIN : S_LOAD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_PTR;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      mem_wdata_q <= 8'h00;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  // NOTE: the word holding register is pure datapath and is always loaded
  // before it is read, so it carries no reset.
  always_ff @(posedge clock) begin
    data_q <= data_d;
    last_q <= last_d;
  end

  assign word_ready = (state_q == S_LOAD) && room;
  assign busy       = (state_q != S_IDLE);
  assign cpu_stall  = busy;
  assign done       = (state_q == S_FIN);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign overflow   = overflow_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives two loaders from shared inputs: a 256-byte instance and an 8-byte
// instance for the overflow scenarios. A monitor records byte writes, word
// acceptances and done pulses of the selected instance; each scenario task
// predicts the write list, word count and overflow from the load rules.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset, start, word_valid, word_last;
  logic [31:0] word_data;

  logic       b_ready, b_we, b_stall, b_busy, b_done, b_ovf;
  logic [7:0] b_addr, b_wdata;
  logic [6:0] b_cnt;
  logic       s_ready, s_we, s_stall, s_busy, s_done, s_ovf;
  logic [7:0] s_addr, s_wdata;
  logic [6:0] s_cnt;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_WIDTH(8), .DEPTH_BYTES(256), .BASE_ADDR(0)) u_big (
    .clock(clock), .reset(reset), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(b_ready),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .cpu_stall(b_stall),
    .busy(b_busy), .done(b_done), .overflow(b_ovf), .word_count(b_cnt));

  imem_loader #(.ADDR_WIDTH(8), .DEPTH_BYTES(8), .BASE_ADDR(0)) u_small (
    .clock(clock), .reset(reset), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(s_ready),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .cpu_stall(s_stall),
    .busy(s_busy), .done(s_done), .overflow(s_ovf), .word_count(s_cnt));

  // Selected instance: 0 = 256-byte, 1 = 8-byte.
  bit         sel = 1'b0;
  logic       m_ready, m_we, m_stall, m_busy, m_done, m_ovf;
  logic [7:0] m_addr, m_wdata;
  logic [6:0] m_cnt;
  assign m_ready = sel ? s_ready : b_ready;
  assign m_we    = sel ? s_we    : b_we;
  assign m_addr  = sel ? s_addr  : b_addr;
  assign m_wdata = sel ? s_wdata : b_wdata;
  assign m_stall = sel ? s_stall : b_stall;
  assign m_busy  = sel ? s_busy  : b_busy;
  assign m_done  = sel ? s_done  : b_done;
  assign m_ovf   = sel ? s_ovf   : b_ovf;
  assign m_cnt   = sel ? s_cnt   : b_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] wr_q[$];    // {addr, byte} per observed write
  int          wrc_q[$];   // cycle of each observed write
  int          acc_q[$];   // cycle of each accepted word
  int          done_cnt, done_cyc, stall_gap;
  int          s_hi_we = 0;
  bit          in_load = 1'b0;
  logic [7:0]  tb_mem [256];

  logic [31:0] stim_w[$];
  bit          stim_l[$];
  int          depth = 256;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (m_we) begin
      wr_q.push_back({m_addr, m_wdata});
      wrc_q.push_back(cyc);
      tb_mem[m_addr] = m_wdata;
    end
    if (word_valid && m_ready) acc_q.push_back(cyc);
    if (m_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (in_load && !m_stall) stall_gap = stall_gap + 1;
    if (s_we && s_addr >= 8'd8) s_hi_we = s_hi_we + 1;
  end

  // Runs one load of stim_w/stim_l on the selected instance and checks it
  // against the expected byte stream derived from the load rules.
  task automatic do_load(input bit hold_valid);
    logic [15:0] exp_wr[$];
    logic [31:0] w;
    int  exp_cnt = 0;
    bit  exp_ovf = 1'b0;
    bit  exp_last = 1'b0;
    int  a = 0;
    int  n, k;
    bit  accepted, finished;

    foreach (stim_w[i]) begin
      if (a > depth - 4) begin exp_ovf = 1'b1; break; end
      w = stim_w[i];
      for (int b = 0; b < 4; b++) exp_wr.push_back({8'(a + b), w[31-8*b -: 8]});
      a += 4;
      exp_cnt++;
      if (stim_l[i]) begin exp_last = 1'b1; break; end
    end

    wr_q.delete(); wrc_q.delete(); acc_q.delete();
    done_cnt = 0; stall_gap = 0;

    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0; in_load = 1'b1;
    @(negedge clock);
    n_checks++; if (m_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_on: got %b want 1", m_stall); end
    n_checks++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL start_clears_ovf: got %b want 0", m_ovf); end
    n_checks++; if (m_cnt !== 7'd0) begin n_fail++; $display("FAIL start_clears_cnt: got %0d want 0", m_cnt); end
    @(posedge clock); #1;

    finished = 1'b0;
    foreach (stim_w[i]) begin
      word_valid = 1'b1; word_data = stim_w[i]; word_last = stim_l[i];
      accepted = 1'b0; n = 0;
      while (!accepted && !finished && n < 60) begin
        @(negedge clock); n++;
        if (m_ready) accepted = 1'b1;
        else if (m_done) finished = 1'b1;
      end
      if (!accepted && !finished) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: word %0d not accepted within 60 cycles", i);
        finished = 1'b1;
      end
      @(posedge clock); #1;
      if (finished || stim_l[i]) break;
      if (!hold_valid) begin
        word_valid = 1'b0;
        k = $urandom_range(0, 3);
        repeat (k) begin @(posedge clock); #1; end
      end
    end
    word_valid = 1'b0; word_last = 1'b0;

    if (!finished) begin
      n = 0;
      while (!m_done && n < 60) begin @(negedge clock); n++; end
      if (!m_done) begin
        n_checks++; n_fail++;
        $display("FAIL done_timeout: no done within 60 cycles");
      end
    end
    in_load = 1'b0;
    @(negedge clock);

    n_checks++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL stall_after_done: got %b want 0", m_stall); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", m_busy); end
    n_checks++; if (m_ovf !== exp_ovf) begin n_fail++; $display("FAIL overflow: got %b want %b", m_ovf, exp_ovf); end
    n_checks++; if (m_cnt !== 7'(exp_cnt)) begin n_fail++; $display("FAIL word_count: got %0d want %0d", m_cnt, exp_cnt); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (stall_gap !== 0) begin n_fail++; $display("FAIL stall_gap: %0d load cycles without stall, want 0", stall_gap); end
    n_checks++; if (acc_q.size() !== exp_cnt) begin n_fail++; $display("FAIL accepted_words: got %0d want %0d", acc_q.size(), exp_cnt); end
    n_checks++; if (wr_q.size() !== exp_wr.size()) begin n_fail++; $display("FAIL write_count: got %0d want %0d", wr_q.size(), exp_wr.size()); end

    for (int j = 0; j < exp_wr.size() && j < wr_q.size(); j++) begin
      n_checks++;
      if (wr_q[j] !== exp_wr[j]) begin
        n_fail++;
        $display("FAIL write_%0d: got (%0d,%h) want (%0d,%h)", j, wr_q[j][15:8], wr_q[j][7:0], exp_wr[j][15:8], exp_wr[j][7:0]);
      end
    end
    for (int j = 0; j < acc_q.size(); j++)
      for (int b = 0; b < 4; b++)
        if (4*j + b < wrc_q.size()) begin
          n_checks++;
          if (wrc_q[4*j+b] !== acc_q[j] + 1 + b) begin
            n_fail++;
            $display("FAIL write_timing w%0d b%0d: cycle %0d want %0d", j, b, wrc_q[4*j+b], acc_q[j] + 1 + b);
          end
        end
    if (hold_valid)
      for (int j = 1; j < acc_q.size(); j++) begin
        n_checks++;
        if (acc_q[j] - acc_q[j-1] !== 5) begin
          n_fail++;
          $display("FAIL ready_spacing w%0d: got %0d cycles want 5", j, acc_q[j] - acc_q[j-1]);
        end
      end
    if (exp_last && wrc_q.size() > 0) begin
      n_checks++;
      if (done_cyc !== wrc_q[wrc_q.size()-1] + 1) begin
        n_fail++;
        $display("FAIL done_timing: cycle %0d want %0d", done_cyc, wrc_q[wrc_q.size()-1] + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", m_ready); end
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", m_we); end
    n_checks++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", m_stall); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", m_busy); end
    n_checks++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", m_done); end
    n_checks++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", m_ovf); end
    n_checks++; if (m_addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", m_addr); end
    n_checks++; if (m_wdata !== 8'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 00", m_wdata); end
    n_checks++; if (m_cnt !== 7'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", m_cnt); end
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL rst_small_busy: got %b want 0", s_busy); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_single_word();
    sel = 1'b0; depth = 256;
    stim_w = '{32'hF800_1FEF}; stim_l = '{1'b1};
    @(negedge clock);
    n_checks++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL stall_before_load: got %b want 0", m_stall); end
    do_load(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    sel = 1'b0; depth = 256;
    stim_w = '{32'h0010_0113, 32'h0020_0193, 32'h0031_00B3};
    stim_l = '{1'b0, 1'b0, 1'b1};
    do_load(1'b1);
    n_checks++;
    if (wr_q.size() == 0 || wr_q[wr_q.size()-1] !== {8'd11, 8'hB3}) begin
      n_fail++; $display("FAIL final_write: got %h want 0bb3", (wr_q.size() == 0) ? 16'h0 : wr_q[wr_q.size()-1]);
    end
    rd = {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]};
    n_checks++; if (rd !== 32'h0020_0193) begin n_fail++; $display("FAIL fetch_pc4: got %h want 00200193", rd); end
  endtask

  task automatic test_random_loads();
    int len;
    sel = 1'b0; depth = 256;
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 6);
      stim_w.delete(); stim_l.delete();
      for (int i = 0; i < len; i++) begin
        stim_w.push_back($urandom);
        stim_l.push_back(i == len - 1);
      end
      do_load(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_exact_fill();
    sel = 1'b0; depth = 256;
    stim_w.delete(); stim_l.delete();
    for (int i = 0; i < 64; i++) begin
      stim_w.push_back($urandom);
      stim_l.push_back(i == 63);
    end
    do_load(1'b1);
  endtask

  task automatic test_overflow();
    sel = 1'b1; depth = 8; s_hi_we = 0;
    stim_w = '{$urandom, $urandom, $urandom}; stim_l = '{1'b0, 1'b0, 1'b0};
    do_load(1'b1);
    n_checks++; if (s_hi_we !== 0) begin n_fail++; $display("FAIL write_past_end: %0d writes at addr>=8, want 0", s_hi_we); end
  endtask

  task automatic test_reload_after_overflow();
    sel = 1'b1; depth = 8;
    stim_w = '{$urandom, $urandom}; stim_l = '{1'b0, 1'b1};
    do_load(1'b0);
  endtask

  task automatic test_reset_mid_load();
    int n, nw;
    bit acc;
    sel = 1'b0; depth = 256;
    reset = 1'b1; start = 1'b0; word_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    word_valid = 1'b1; word_data = $urandom; word_last = 1'b0;
    for (int j = 0; j < 2; j++) begin
      acc = 1'b0; n = 0;
      while (!acc && n < 60) begin @(negedge clock); n++; if (m_ready) acc = 1'b1; end
      if (!acc) begin n_checks++; n_fail++; $display("FAIL mid_accept_timeout: word %0d", j); end
      @(posedge clock); #1 word_data = $urandom;
    end
    word_valid = 1'b0;
    n = 0;
    while (!(m_we && m_addr == 8'd5) && n < 20) begin @(negedge clock); n++; end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    nw = wr_q.size();
    n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we: got %b want 0", m_we); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", m_busy); end
    n_checks++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %b want 0", m_stall); end
    n_checks++; if (m_cnt !== 7'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", m_cnt); end
    n_checks++; if (m_addr !== 8'd0) begin n_fail++; $display("FAIL mid_rst_addr: got %0d want 0", m_addr); end
    repeat (4) @(negedge clock);
    n_checks++; if (wr_q.size() !== nw) begin n_fail++; $display("FAIL mid_rst_writes: got %0d extra writes want 0", wr_q.size() - nw); end
  endtask

  task automatic test_start_ignored();
    int nw;
    sel = 1'b0; depth = 256;
    stim_w = '{$urandom, $urandom, $urandom}; stim_l = '{1'b0, 1'b0, 1'b1};
    fork
      do_load(1'b1);
      begin
        int m;
        m = 0;
        while (!(m_we && m_addr == 8'd6) && m < 100) begin @(negedge clock); m++; end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
    join
    word_valid = 1'b1; word_data = $urandom; word_last = 1'b1;
    nw = wr_q.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready cyc%0d: got %b want 0", i, m_ready); end
    end
    word_valid = 1'b0; word_last = 1'b0;
    @(negedge clock);
    n_checks++; if (wr_q.size() !== nw) begin n_fail++; $display("FAIL idle_writes: got %0d want 0", wr_q.size() - nw); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", m_busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
    done_cnt = 0; done_cyc = 0; stall_gap = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random_loads();
    test_exact_fill();
    test_overflow();
    test_reload_after_overflow();
    test_reset_mid_load();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the byte-addressed, big-endian instruction memory.
- Accepts 32-bit program words over a valid/ready stream and breaks each into four sequential byte writes (MSB first) at consecutive byte addresses.
- Holds the pipeline stalled while loading and reports completion or overflow.
- Sits between the test/boot source and the instruction memory's write port.

Parameters:
- ADDR_WIDTH, 8, byte-address width of the instruction memory.
- DEPTH_BYTES, 256, instruction memory size in bytes; must be a multiple of 4.
- BASE_ADDR, 0, first byte address written by each load; must be 4-aligned.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- word_valid  in  1  source presents a word.
- word_data  in  32  program word; bits [31:24] go to the lowest address.
- word_last  in  1  qualifies word_data as the final word of the program.
- word_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  byte write strobe to the instruction memory.
- mem_addr  out  ADDR_WIDTH  byte address of the write.
- mem_wdata  out  8  byte to write.
- cpu_stall  out  1  drives the pipeline stall; high for the whole load.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load terminates.
- overflow  out  1  sticky error flag, cleared by start or reset.
- word_count  out  ADDR_WIDTH-1  number of fully written words in the current or last load.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - word_ready, mem_we, cpu_stall, busy, done and overflow all go to 0.
  - mem_addr = BASE_ADDR; mem_wdata = 0; word_count = 0.
  - Reset mid-load abandons any partially written word; no further mem_we is issued.
- States:
  - IDLE: if start=1, go to LOAD next cycle. On that transition: addr = BASE_ADDR, word_count = 0, overflow = 0, cpu_stall = 1.
  - LOAD: word_ready = 1 only if addr <= DEPTH_BYTES-4.
    - On word_valid & word_ready: latch word_data and word_last, go to WR0.
    - If addr > DEPTH_BYTES-4 and word_valid = 1: set overflow = 1, go to FIN, no write issued.
  - WR0..WR3: one byte per cycle, mem_we = 1.
    - WR0 writes bits [31:24] at addr, WR1 writes [23:16] at addr+1, WR2 writes [15:8] at addr+2, WR3 writes [7:0] at addr+3.
    - At the end of WR3: addr += 4, word_count += 1. Go to FIN if the latched last = 1, otherwise back to LOAD.
  - FIN: done = 1 for exactly this cycle; cpu_stall stays 1. Go to IDLE next cycle, where cpu_stall = 0.
- Timing:
  - If a word is accepted at cycle N, its byte writes occur at N+1 through N+4.
  - word_ready next asserts at N+5, so sustained throughput is one word per 5 cycles.
  - word_ready is registered state, never combinationally dependent on word_valid.
- Edge cases:
  - start while busy is ignored.
  - word_valid while in IDLE is ignored, and word_ready stays 0.
  - A word with word_last=1 that exactly fills memory (addr = DEPTH_BYTES-4) is legal and sets no overflow.
  - Address arithmetic never wraps: the overflow check happens before any write.
- Outputs: mem_addr and mem_wdata are don't-care when mem_we = 0, but are held stable. overflow and word_count persist in IDLE until the next start.

Test Plan:
- Reset, start, then send one word 0xF800_1FEF with last=1. Required: writes (0,F8) (1,00) (2,1F) (3,EF) on 4 consecutive cycles; done pulses 1 cycle later; word_count = 1; cpu_stall goes high→low around the load.
- Send 3 words 0x0010_0113, 0x0020_0193, 0x0031_00B3 (last on the 3rd) with word_valid held high. Required: word_ready spaced 5 cycles apart; final byte write is (11, B3); word_count = 3; reading the memory back via fetch at pc = 4 yields 0x0020_0193.
- With DEPTH_BYTES = 8, send 3 words without last. Required: addresses 0–7 are written; the 3rd word is never accepted (word_ready = 0); overflow = 1; done pulses; no mem_we at addr ≥ 8.
- Assert reset during WR1 of the second word. Required: no mem_we on the following cycles; state is IDLE; cpu_stall = 0; word_count = 0.
- Pulse start during WR2. Required: ignored, with the address sequence unchanged. Then assert word_valid in IDLE after done. Required: word_ready stays 0 and no writes occur.
- Second load after an overflowed load. Required: start clears overflow and word_count and restarts at BASE_ADDR.
